target_gen_lfsr: RTL

Parametrised pseudo-random target generator for the note/target engine. A programmable tick divider paces generation, and a Galois LFSR produces a new target index in [0, NUM_TARGETS) plus a note length on each tick. Results are held in a single-entry valid/ready output buffer consumed by the note scheduler. Supports seed loading, an optional no-immediate-repeat mode and a dropped-target counter.

---
 rtl/target_gen_lfsr_if.sv | 23 ++
 rtl/target_gen_lfsr.sv | 97 +++++++++
 2 files changed

// File: rtl/target_gen_lfsr_if.sv
// Valid/ready target stream from the generator to the note scheduler.
interface target_gen_lfsr_if #(
  parameter int unsigned TW = 4
) ();
  logic          target_valid;
  logic          target_ready;
  logic [TW-1:0] target;
  logic [2:0]    target_len;

  modport master (
    output target_valid,
    output target,
    output target_len,
    input  target_ready
  );

  modport slave (
    input  target_valid,
    input  target,
    input  target_len,
    output target_ready
  );
endinterface

// File: rtl/target_gen_lfsr.sv
// Pseudo-random target generator: tick divider paces a Galois LFSR whose next
// state is mapped to a target lane and note length, held in a one-entry buffer.
module target_gen_lfsr #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  TAPS        = 32'h80200003,
  parameter logic [WIDTH-1:0]  SEED        = 32'h00000001,
  parameter int unsigned       TICK_DIV    = 25000000,
  parameter int unsigned       NUM_TARGETS = 10,
  parameter int unsigned       TW          = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                enable,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed,
  input  logic                no_repeat,
  target_gen_lfsr_if.master   tgt,
  output logic                tick,
  output logic [WIDTH-1:0]    lfsr_state,
  output logic [7:0]          drop_count
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [31:0] NT = 32'(NUM_TARGETS);

  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_next;
  logic             valid_q;
  logic [TW-1:0]    target_q;
  logic [2:0]       len_q;
  logic [7:0]       drop_q;
  logic [TW-1:0]    last_q;
  logic             have_last_q;
  logic [TW-1:0]    raw;
  logic [TW-1:0]    pick;
  logic [2:0]       len_new;

  assign tick = enable && (count_q == CW'(TICK_DIV - 1)) && !seed_load;

  // Galois step plus mapping of the stepped value to lane and length.
  always_comb begin
    lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    // Top 16 bits scaled into [0, NUM_TARGETS); the product always fits 32 bits.
    raw       = TW'((32'(lfsr_next[WIDTH-1 -: 16]) * NT) >> 16);
    len_new   = {1'b0, lfsr_next[1:0]} + 3'd1;
    pick      = raw;
    if (no_repeat && have_last_q && (raw == last_q)) begin
      // With a single lane this wraps back to 0, so the rule is a no-op.
      pick = (raw == TW'(NUM_TARGETS - 1)) ? '0 : raw + TW'(1);
    end
  end

  // Counter, LFSR, output buffer and drop counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q     <= '0;
      lfsr_q      <= SEED;
      valid_q     <= 1'b0;
      target_q    <= '0;
      len_q       <= 3'd1;
      drop_q      <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
    end else begin
      // A transfer empties the buffer unless a tick refills it below.
      if (valid_q && tgt.target_ready) valid_q <= 1'b0;

      if (seed_load) begin
        lfsr_q      <= (seed == '0) ? WIDTH'(1) : seed;
        count_q     <= '0;
        have_last_q <= 1'b0;
      end else if (tick) begin
        count_q <= '0;
        lfsr_q  <= lfsr_next;
        if (!valid_q || tgt.target_ready) begin
          valid_q     <= 1'b1;
          target_q    <= pick;
          len_q       <= len_new;
          last_q      <= pick;
          have_last_q <= 1'b1;
        end else if (drop_q != 8'hFF) begin
          drop_q <= drop_q + 8'd1;
        end
      end else if (enable) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

  assign tgt.target_valid = valid_q;
  assign tgt.target       = target_q;
  assign tgt.target_len   = len_q;
  assign lfsr_state       = lfsr_q;
  assign drop_count       = drop_q;

endmodule
